quad_encoder_gen: RTL and testbench
===================================

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of period, step-count and position fields.
REQ-002 SHALL have parameter COUNTS_PER_REV, default 64: quadrature counts per revolution, used for index generation; legal range 4..2^DATA_WIDTH, multiple of 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 cmd_valid  input  1  command offered this cycle.
REQ-006 cmd_ready  output  1  block accepts a command this cycle.
REQ-007 cmd_dir  input  1  1 = forward, 0 = reverse.
REQ-008 cmd_period  input  DATA_WIDTH  clocks per quadrature step; 0 = stop command.
REQ-009 cmd_steps  input  DATA_WIDTH  steps to emit; 0 = run continuously.
REQ-010 encoder_a, encoder_b  output  1 each  quadrature phase outputs, registered.
REQ-011 encoder_z  output  1  index pulse.
REQ-012 position  output  DATA_WIDTH  signed two's-complement step count since reset.
REQ-013 step_strobe  output  1  one-cycle pulse on every quadrature transition.
REQ-014 busy  output  1  high while in RUN.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, RUN.
REQ-016 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_dir, cmd_period and cmd_steps are latched on that edge.
REQ-017 cmd_ready SHALL be 1 in IDLE, 1 in RUN when latched steps = 0 (continuous), and 0 in RUN when latched steps != 0 (bounded move).
REQ-018 Accepted command with cmd_period != 0: FSM -> RUN, period counter cleared to 0; a command accepted during continuous RUN replaces dir, period and steps immediately and clears the period counter.
REQ-019 Accepted command with cmd_period = 0: FSM -> IDLE on that edge; phase outputs hold their current values; no step is emitted.
REQ-020 In RUN the period counter SHALL increment each cycle; when it equals latched period-1 it returns to 0 and one step is emitted on that same edge.
REQ-021 First step SHALL occur on the cmd_period-th rising edge after the accepting edge; period = 1 yields one step every cycle.
REQ-022 Forward step sequence of {encoder_a, encoder_b}: 00 -> 01 -> 11 -> 10 -> 00; reverse is the exact inverse. Exactly one phase SHALL change per step.
REQ-023 On each step: position +1 (forward) or -1 (reverse), wrapping modulo 2^DATA_WIDTH; step_strobe = 1 for that cycle only.
REQ-024 Revolution counter (0..COUNTS_PER_REV-1) SHALL increment on forward steps and decrement on reverse steps, wrapping at both ends.
REQ-025 encoder_z SHALL be 1 exactly when revolution counter = 0 and {encoder_a, encoder_b} = 00.
REQ-026 Bounded move: remaining count loaded from cmd_steps, decremented per step; the step that brings it to 0 is emitted and FSM -> IDLE on the same edge; busy drops on that edge.
REQ-027 cmd_valid while cmd_ready = 0 SHALL be ignored; no state change.
REQ-028 Phase state, position and revolution counter SHALL persist across IDLE; a new command continues from the current phase.
REQ-029 Direction reversal in continuous RUN SHALL emit the inverse sequence from the current phase, with no glitch or skipped state.

Reset
REQ-030 While reset = 0: FSM = IDLE, encoder_a = 0, encoder_b = 0, position = 0, revolution counter = 0, encoder_z = 1, step_strobe = 0, busy = 0, cmd_ready = 1, period counter = 0, remaining steps = 0.
REQ-031 Reset asserted mid-move SHALL abort immediately and asynchronously; no further steps are emitted until a new command is accepted after release.

Verification
REQ-032 Accept dir=1, period=3, steps=4 from reset -> AB = 01, 11, 10, 00 at edges +3, +6, +9, +12; position = 4; busy falls at +12; cmd_ready = 0 during the move.
REQ-033 Accept dir=0, period=1, steps=0 from reset -> AB = 10, 11, 01, 00 on consecutive cycles; position = -1, -2, -3, -4 (0xFFFF..0xFFFC); step_strobe high every cycle.
REQ-034 Continuous forward run, period=2, COUNTS_PER_REV=8 -> encoder_z high for exactly one step interval every 8 steps; position wraps 0x7FFF -> 0x8000 without a glitch.
REQ-035 Continuous run, then cmd_period=0 accepted -> busy = 0 on the next edge, AB frozen; a new command resumes from the frozen phase.
REQ-036 Reset pulsed low mid bounded move -> all outputs at reset values asynchronously; cmd_valid offered during a bounded move is ignored.

Source files
------------

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder pattern generator: emits A/B/Z phases at a programmable step period,
// for bounded moves or continuous runs, and tracks signed position and revolution index.
module quad_encoder_gen #(
    parameter int DATA_WIDTH     = 16,
    parameter int COUNTS_PER_REV = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [DATA_WIDTH-1:0] cmd_period,
    input  logic [DATA_WIDTH-1:0] cmd_steps,
    output logic                  encoder_a,
    output logic                  encoder_b,
    output logic                  encoder_z,
    output logic [DATA_WIDTH-1:0] position,
    output logic                  step_strobe,
    output logic                  busy
);

    localparam int                REV_W   = $clog2(COUNTS_PER_REV);
    localparam logic [REV_W-1:0]  REV_MAX = REV_W'(COUNTS_PER_REV - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_dir, w_dir_nxt;
    logic [DATA_WIDTH-1:0] r_period, w_period_nxt;
    logic [DATA_WIDTH-1:0] r_remaining, w_remaining_nxt;
    logic [DATA_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]            r_ab, w_ab_nxt;
    logic [DATA_WIDTH-1:0] r_pos, w_pos_nxt;
    logic [REV_W-1:0]      r_rev, w_rev_nxt;
    logic                  r_strobe, w_strobe_nxt;
    logic                  w_accept;
    logic                  w_step;

    // Remaining count of zero while running marks a continuous run, which may be retargeted.
    assign cmd_ready = (r_state == S_IDLE) || (r_remaining == '0);
    assign w_accept  = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b0;
            r_period    <= '0;
            r_remaining <= '0;
            r_cnt       <= '0;
            r_ab        <= 2'b00;
            r_pos       <= '0;
            r_rev       <= '0;
            r_strobe    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dir       <= w_dir_nxt;
            r_period    <= w_period_nxt;
            r_remaining <= w_remaining_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ab        <= w_ab_nxt;
            r_pos       <= w_pos_nxt;
            r_rev       <= w_rev_nxt;
            r_strobe    <= w_strobe_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dir_nxt       = r_dir;
        w_period_nxt    = r_period;
        w_remaining_nxt = r_remaining;
        w_cnt_nxt       = r_cnt;
        w_ab_nxt        = r_ab;
        w_pos_nxt       = r_pos;
        w_rev_nxt       = r_rev;
        w_strobe_nxt    = 1'b0;
        w_step          = 1'b0;

        // A newly accepted command takes the edge; no step is emitted on an accepting edge.
        if (w_accept) begin
            w_dir_nxt       = cmd_dir;
            w_period_nxt    = cmd_period;
            w_remaining_nxt = cmd_steps;
            w_cnt_nxt       = '0;
            w_state_nxt     = (cmd_period != '0) ? S_RUN : S_IDLE;
        end else if (r_state == S_RUN) begin
            if (r_cnt == r_period - DATA_WIDTH'(1)) begin
                w_cnt_nxt = '0;
                w_step    = 1'b1;
                if (r_remaining != '0) begin
                    w_remaining_nxt = r_remaining - DATA_WIDTH'(1);
                    if (r_remaining == DATA_WIDTH'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end else begin
                w_cnt_nxt = r_cnt + DATA_WIDTH'(1);
            end
        end

        // Gray-code walk: forward 00->01->11->10, reverse is the inverse.
        if (w_step) begin
            w_strobe_nxt = 1'b1;
            if (r_dir) begin
                w_ab_nxt  = {r_ab[0], ~r_ab[1]};
                w_pos_nxt = r_pos + DATA_WIDTH'(1);
                w_rev_nxt = (r_rev == REV_MAX) ? '0 : r_rev + REV_W'(1);
            end else begin
                w_ab_nxt  = {~r_ab[0], r_ab[1]};
                w_pos_nxt = r_pos - DATA_WIDTH'(1);
                w_rev_nxt = (r_rev == '0) ? REV_MAX : r_rev - REV_W'(1);
            end
        end
    end

    assign encoder_a   = r_ab[1];
    assign encoder_b   = r_ab[0];
    assign encoder_z   = (r_rev == '0) && (r_ab == 2'b00);
    assign position    = r_pos;
    assign step_strobe = r_strobe;
    assign busy        = (r_state == S_RUN);

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen: expected steps are queued when commands are driven
// and popped by a negedge monitor whenever the generator strobes a step.
module tb_quad_encoder_gen;

    localparam int DW  = 16;
    localparam int CPR = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [DW-1:0] cmd_period = '0;
    logic [DW-1:0] cmd_steps = '0;
    logic          cmd_ready;
    logic          encoder_a, encoder_b, encoder_z;
    logic [DW-1:0] position;
    logic          step_strobe;
    logic          busy;

    quad_encoder_gen #(.DATA_WIDTH(DW), .COUNTS_PER_REV(CPR)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .cmd_steps  (cmd_steps),
        .encoder_a  (encoder_a),
        .encoder_b  (encoder_b),
        .encoder_z  (encoder_z),
        .position   (position),
        .step_strobe(step_strobe),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    ab;
        logic [DW-1:0] pos;
        logic          z;
    } step_t;

    step_t      sb_q[$];
    step_t      exp_s = '{ab: 2'b00, pos: '0, z: 1'b1};
    int         checks = 0;
    int         errors = 0;
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         m_idx;
    int         m_rev;
    logic [DW-1:0] m_pos;
    int         zc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0;
        m_rev = 0;
        m_pos = '0;
    endtask

    task automatic push_steps(input logic dir, input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            if (dir) begin
                m_idx = (m_idx + 1) % 4;
                m_rev = (m_rev + 1) % CPR;
                m_pos = m_pos + 1'b1;
            end else begin
                m_idx = (m_idx + 3) % 4;
                m_rev = (m_rev + CPR - 1) % CPR;
                m_pos = m_pos - 1'b1;
            end
            s.ab  = seq[m_idx];
            s.pos = m_pos;
            s.z   = (m_rev == 0) && (seq[m_idx] == 2'b00);
            sb_q.push_back(s);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        sb_q.delete();
        @(negedge clk);
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic chk_drained(input string tag);
        @(negedge clk);
        #1;
        chk(tag, 32'(sb_q.size()), 32'd0);
        tick();
    endtask

    task automatic send(input logic dir, input logic [DW-1:0] per, input logic [DW-1:0] stp);
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_period = per;
        cmd_steps  = stp;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            exp_s.ab  = 2'b00;
            exp_s.pos = '0;
            exp_s.z   = 1'b1;
        end else begin
            if (step_strobe) begin
                checks++;
                assert (sb_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_step observed=strobe expected=no_step pos=%0h", position);
                end
                if (sb_q.size() > 0) exp_s = sb_q.pop_front();
            end
            chk("mon_ab", 32'({encoder_a, encoder_b}), 32'(exp_s.ab));
            chk("mon_pos", 32'(position), 32'(exp_s.pos));
            chk("mon_z", 32'(encoder_z), 32'(exp_s.z));
        end
    end

    initial begin
        model_reset();
        #12;
        chk("rst_ab", 32'({encoder_a, encoder_b}), 32'd0);
        chk("rst_pos", 32'(position), 32'd0);
        chk("rst_z", 32'(encoder_z), 32'd1);
        chk("rst_strobe", 32'(step_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        tick();

        // Bounded forward move, period 3, 4 steps; a command offered mid-move must be ignored.
        send(1'b1, 16'd3, 16'd4);
        push_steps(1'b1, 4);
        tick();
        cmd_valid = 1'b0;
        chk("a_ready_move", 32'(cmd_ready), 32'd0);
        chk("a_busy_move", 32'(busy), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) send(1'b0, 16'd1, 16'd0);
            if (k == 7) cmd_valid = 1'b0;
            tick();
            chk("a_strobe_timing", 32'(step_strobe), 32'((k % 3) == 0));
            chk("a_busy", 32'(busy), 32'(k < 12));
            chk("a_ready", 32'(cmd_ready), 32'(k >= 12));
        end
        chk("a_pos_end", 32'(position), 32'd4);
        chk("a_ab_end", 32'({encoder_a, encoder_b}), 32'd0);
        chk_drained("a_drained");

        // Continuous reverse at period 1 from reset, then stop.
        do_reset();
        send(1'b0, 16'd1, 16'd0);
        push_steps(1'b0, 4);
        tick();
        cmd_valid = 1'b0;
        chk("b_ready_cont", 32'(cmd_ready), 32'd1);
        chk("b_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("b_strobe_every", 32'(step_strobe), 32'd1);
        end
        send(1'b0, 16'd0, 16'd0);
        tick();
        cmd_valid = 1'b0;
        chk("b_stop_busy", 32'(busy), 32'd0);
        chk("b_stop_strobe", 32'(step_strobe), 32'd0);
        chk("b_stop_pos", 32'(position), 32'h0000FFFC);

        // Continuous forward, stop mid-sequence, resume from the frozen phase.
        send(1'b1, 16'd2, 16'd0);
        push_steps(1'b1, 3);
        tick();
        cmd_valid = 1'b0;
        repeat (6) tick();
        send(1'b1, 16'd0, 16'd0);
        tick();
        cmd_valid = 1'b0;
        chk("c_stop_busy", 32'(busy), 32'd0);
        chk("c_frozen_ab", 32'({encoder_a, encoder_b}), 32'b10);
        repeat (3) tick();
        chk("c_still_frozen", 32'({encoder_a, encoder_b}), 32'b10);
        chk("c_idle_strobe", 32'(step_strobe), 32'd0);
        send(1'b0, 16'd1, 16'd2);
        push_steps(1'b0, 2);
        tick();
        cmd_valid = 1'b0;
        chk("c_ready_bounded", 32'(cmd_ready), 32'd0);
        tick();
        tick();
        chk("c_busy_end", 32'(busy), 32'd0);
        chk("c_pos_end", 32'(position), 32'h0000FFFD);
        chk("c_ab_end", 32'({encoder_a, encoder_b}), 32'b01);
        chk_drained("c_drained");

        // Reset pulsed mid bounded move aborts asynchronously.
        do_reset();
        send(1'b1, 16'd2, 16'd10);
        push_steps(1'b1, 2);
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        chk("d_abort_busy", 32'(busy), 32'd0);
        chk("d_abort_ab", 32'({encoder_a, encoder_b}), 32'd0);
        chk("d_abort_pos", 32'(position), 32'd0);
        chk("d_abort_z", 32'(encoder_z), 32'd1);
        chk("d_abort_ready", 32'(cmd_ready), 32'd1);
        chk("d_abort_strobe", 32'(step_strobe), 32'd0);
        chk("d_drained_at_abort", 32'(sb_q.size()), 32'd0);
        model_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("d_no_step", 32'(step_strobe), 32'd0);
            chk("d_idle", 32'(busy), 32'd0);
        end

        // Index pulse every 8 steps, then a fast run through the signed wrap.
        send(1'b1, 16'd2, 16'd0);
        push_steps(1'b1, 32);
        tick();
        cmd_valid = 1'b0;
        zc = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (encoder_z) zc++;
        end
        chk("e_z_cycles", 32'(zc), 32'd8);
        send(1'b1, 16'd1, 16'd0);
        push_steps(1'b1, 32736);
        tick();
        cmd_valid = 1'b0;
        repeat (32736) tick();
        send(1'b1, 16'd0, 16'd0);
        tick();
        cmd_valid = 1'b0;
        chk("e_wrap_pos", 32'(position), 32'h00008000);
        chk("e_wrap_busy", 32'(busy), 32'd0);
        chk_drained("e_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
